// File: rtl/timer_sequencer_if.sv
// Purpose : Avalon-MM bus between the timer sequencer (master) and the
//           16-bit interval timer (slave), plus the timer interrupt line.
// Ports   : avm_address/chipselect/write_n/writedata (master -> slave),
//           avm_readdata/timer_irq (slave -> master). Bus has no wait states.
interface timer_sequencer_if;
   logic [2:0]  avm_address;
   logic        avm_chipselect;
   logic        avm_write_n;
   logic [15:0] avm_writedata;
   logic [15:0] avm_readdata;
   logic        timer_irq;

   modport master (
      output avm_address, avm_chipselect, avm_write_n, avm_writedata,
      input  avm_readdata, timer_irq
   );

   modport slave (
      input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
      output avm_readdata, timer_irq
   );
endinterface

// File: rtl/timer_sequencer.sv
// Purpose : programs/verifies/starts the interval timer, acknowledges each
//           timeout and keeps hh:mm:ss wall-clock time with a minute alarm.
// Latency : start -> running 5 cycles; irq -> tick 2 cycles (TICKS_PER_SEC=1).
// Backpr. : none; bus is zero-wait, one access per cycle, Moore on state.
// Ports   : clk/reset (sync, active high); start/stop/set_time control pulses;
//           set_*/alarm_* time values; bus (master modport); hh/mm/ss time;
//           tick/alarm pulses; running/busy state flags; cfg_error sticky.
module timer_sequencer #(
   parameter int unsigned PERIOD        = 50000000,
   parameter int unsigned TICKS_PER_SEC = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                stop,
   input  logic                set_time,
   input  logic [4:0]          set_hh,
   input  logic [5:0]          set_mm,
   input  logic                alarm_en,
   input  logic [4:0]          alarm_hh,
   input  logic [5:0]          alarm_mm,
   timer_sequencer_if.master   bus,
   output logic [4:0]          hh,
   output logic [5:0]          mm,
   output logic [5:0]          ss,
   output logic                tick,
   output logic                alarm,
   output logic                running,
   output logic                cfg_error,
   output logic                busy
);

   typedef enum logic [3:0] {
      S_IDLE, S_WR_PL, S_WR_PH, S_RD_PL, S_RD_CHK,
      S_WR_CTRL, S_RUN, S_CLR, S_CLR_WAIT, S_STOP_WR
   } state_t;

   localparam logic [31:0] PERIOD_M1 = 32'(PERIOD - 1);
   localparam logic [9:0]  SUB_LAST  = 10'(TICKS_PER_SEC - 1);

   state_t      state_q, state_d;
   logic        stop_pend_q, stop_pend_d;
   logic        cfg_error_q, cfg_error_d;
   logic [9:0]  sub_q, sub_d;
   logic        inc_pend_q, inc_pend_d;
   logic [4:0]  hh_q, hh_d;
   logic [5:0]  mm_q, mm_d;
   logic [5:0]  ss_q, ss_d;
   logic        tick_q, tick_d;
   logic        alarm_q, alarm_d;
   logic        running_q, running_d;
   logic        busy_q, busy_d;
   logic [2:0]  addr_q, addr_d;
   logic        cs_q, cs_d;
   logic        wn_q, wn_d;
   logic [15:0] wd_q, wd_d;

   // Control FSM: next state, pending stop and config error flag.
   always_comb begin
      state_d     = state_q;
      stop_pend_d = stop_pend_q;
      cfg_error_d = cfg_error_q;
      case (state_q)
         S_IDLE:    if (start && !stop) begin
                       state_d     = S_WR_PL;
                       cfg_error_d = 1'b0;
                    end
         S_WR_PL:   state_d = S_WR_PH;
         S_WR_PH:   state_d = S_RD_PL;
         S_RD_PL:   state_d = S_RD_CHK;
         S_RD_CHK:  if (bus.avm_readdata != PERIOD_M1[15:0]) begin
                       cfg_error_d = 1'b1;
                       state_d     = S_STOP_WR;
                    end else begin
                       state_d     = S_WR_CTRL;
                    end
         S_WR_CTRL: state_d = S_RUN;
         S_RUN:     if (bus.timer_irq) begin
                       // servicing the timeout first; a coincident stop is kept
                       state_d = S_CLR;
                       if (stop) stop_pend_d = 1'b1;
                    end else if (stop) begin
                       state_d = S_STOP_WR;
                    end
         S_CLR:     begin
                       if (stop) stop_pend_d = 1'b1;
                       state_d = S_CLR_WAIT;
                    end
         S_CLR_WAIT: state_d = (stop_pend_q || stop) ? S_STOP_WR : S_RUN;
         S_STOP_WR: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
      if (state_d == S_IDLE) stop_pend_d = 1'b0;
   end

   // Bus access decoded from the next state so the registered bus
   // outputs line up with the state they belong to.
   always_comb begin
      cs_d   = 1'b0;
      wn_d   = 1'b1;
      addr_d = 3'd0;
      wd_d   = 16'h0000;
      case (state_d)
         S_WR_PL:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd2; wd_d = PERIOD_M1[15:0];  end
         S_WR_PH:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd3; wd_d = PERIOD_M1[31:16]; end
         S_RD_PL:   begin cs_d = 1'b1; addr_d = 3'd2; end
         S_WR_CTRL: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = 16'h0007; end
         S_CLR:     begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0; wd_d = 16'h0000; end
         S_STOP_WR: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = 16'h0008; end
         default:   ;
      endcase
      running_d = (state_d == S_RUN) || (state_d == S_CLR) || (state_d == S_CLR_WAIT);
      busy_d    = (state_d != S_IDLE) && (state_d != S_RUN);
   end

   // Timekeeping: CLR advances the sub-counter; a wrap schedules the
   // second increment (and tick) for the following cycle.
   always_comb begin
      sub_d      = sub_q;
      inc_pend_d = 1'b0;
      hh_d       = hh_q;
      mm_d       = mm_q;
      ss_d       = ss_q;
      tick_d     = 1'b0;
      alarm_d    = 1'b0;
      if (state_q == S_CLR) begin
         if (sub_q >= SUB_LAST) begin
            sub_d      = 10'd0;
            inc_pend_d = 1'b1;
         end else begin
            sub_d = sub_q + 10'd1;
         end
      end
      if (inc_pend_q) begin
         tick_d = 1'b1;
         if (ss_q == 6'd59) begin
            ss_d = 6'd0;
            if (mm_q == 6'd59) begin
               mm_d = 6'd0;
               hh_d = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
            end else begin
               mm_d = mm_q + 6'd1;
            end
         end else begin
            ss_d = ss_q + 6'd1;
         end
         alarm_d = alarm_en && (hh_d == alarm_hh) && (mm_d == alarm_mm) && (ss_d == 6'd0);
      end
      // set_time overrides any increment in flight, without tick or alarm
      if (set_time) begin
         hh_d       = (set_hh > 5'd23) ? 5'd23 : set_hh;
         mm_d       = (set_mm > 6'd59) ? 6'd59 : set_mm;
         ss_d       = 6'd0;
         sub_d      = 10'd0;
         inc_pend_d = 1'b0;
         tick_d     = 1'b0;
         alarm_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         stop_pend_q <= 1'b0;
         cfg_error_q <= 1'b0;
         sub_q       <= 10'd0;
         inc_pend_q  <= 1'b0;
         hh_q        <= 5'd0;
         mm_q        <= 6'd0;
         ss_q        <= 6'd0;
         tick_q      <= 1'b0;
         alarm_q     <= 1'b0;
         running_q   <= 1'b0;
         busy_q      <= 1'b0;
         addr_q      <= 3'd0;
         cs_q        <= 1'b0;
         wn_q        <= 1'b1;
         wd_q        <= 16'h0000;
      end else begin
         state_q     <= state_d;
         stop_pend_q <= stop_pend_d;
         cfg_error_q <= cfg_error_d;
         sub_q       <= sub_d;
         inc_pend_q  <= inc_pend_d;
         hh_q        <= hh_d;
         mm_q        <= mm_d;
         ss_q        <= ss_d;
         tick_q      <= tick_d;
         alarm_q     <= alarm_d;
         running_q   <= running_d;
         busy_q      <= busy_d;
         addr_q      <= addr_d;
         cs_q        <= cs_d;
         wn_q        <= wn_d;
         wd_q        <= wd_d;
      end
   end

   assign bus.avm_address    = addr_q;
   assign bus.avm_chipselect = cs_q;
   assign bus.avm_write_n    = wn_q;
   assign bus.avm_writedata  = wd_q;
   assign hh        = hh_q;
   assign mm        = mm_q;
   assign ss        = ss_q;
   assign tick      = tick_q;
   assign alarm     = alarm_q;
   assign running   = running_q;
   assign cfg_error = cfg_error_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Purpose : self-checking bench for timer_sequencer (PERIOD=50, TICKS_PER_SEC=1)
//           with a register-level timer model and bus/tick scoreboards.
// Ports   : none (top level).
module tb_timer_sequencer;

   logic       clk = 1'b0;
   logic       reset, start, stop, set_time, alarm_en;
   logic [4:0] set_hh, alarm_hh;
   logic [5:0] set_mm, alarm_mm;
   logic [4:0] hh;
   logic [5:0] mm, ss;
   logic       tick, alarm, running, cfg_error, busy;
   logic       corrupt;
   logic [15:0] tregs [0:7];

   always #5 clk = ~clk;

   timer_sequencer_if bus();

   timer_sequencer #(.PERIOD(50), .TICKS_PER_SEC(1)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .set_time(set_time), .set_hh(set_hh), .set_mm(set_mm),
      .alarm_en(alarm_en), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
      .bus(bus), .hh(hh), .mm(mm), .ss(ss), .tick(tick), .alarm(alarm),
      .running(running), .cfg_error(cfg_error), .busy(busy)
   );

   // Timer register model: registered readdata, optional corrupted readback.
   always @(posedge clk) begin
      if (bus.avm_chipselect && !bus.avm_write_n)
         tregs[bus.avm_address] <= bus.avm_writedata;
      bus.avm_readdata <= (bus.avm_chipselect && bus.avm_write_n && !corrupt)
                          ? tregs[bus.avm_address] : 16'h0000;
   end

   logic [19:0] bus_q [$];   // {addr, write_n, writedata}
   logic [17:0] tick_q [$];  // {hh, mm, ss, alarm}
   int checks = 0, failures = 0, tick_cnt = 0, alarm_cnt = 0;
   int m_hh = 0, m_mm = 0, m_ss = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic monitor();
      logic [19:0] eb;
      logic [17:0] et;
      forever begin
         @(negedge clk);
         if (bus.avm_chipselect) begin
            if (bus_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL bus_unexpected: got addr=%0d wn=%0b wd=0x%0h expected no access",
                        bus.avm_address, bus.avm_write_n, bus.avm_writedata);
            end else begin
               eb = bus_q.pop_front();
               chk("bus_access", {bus.avm_address, bus.avm_write_n, bus.avm_writedata}, eb);
            end
         end
         if (tick) begin
            tick_cnt++;
            if (alarm) alarm_cnt++;
            if (tick_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL tick_unexpected: got tick at %0d:%0d:%0d expected none", hh, mm, ss);
            end else begin
               et = tick_q.pop_front();
               chk("tick_time_alarm", {hh, mm, ss, alarm}, et);
            end
         end else if (alarm) begin
            checks++; failures++;
            $display("FAIL alarm_no_tick: got alarm=1 expected 0");
         end
      end
   endtask

   task automatic push_prog(input bit ok);
      bus_q.push_back({3'd2, 1'b0, 16'h0031});
      bus_q.push_back({3'd3, 1'b0, 16'h0000});
      bus_q.push_back({3'd2, 1'b1, 16'h0000});
      bus_q.push_back(ok ? {3'd1, 1'b0, 16'h0007} : {3'd1, 1'b0, 16'h0008});
   endtask

   task automatic start_ok();
      push_prog(1'b1);
      start = 1'b1; cyc(1); start = 1'b0;
      cyc(4); chk("running_before_6th", int'(running), 0);
      cyc(1); chk("running_6th", int'(running), 1);
      chk("cfg_error_ok", int'(cfg_error), 0);
   endtask

   task automatic do_stop();
      bus_q.push_back({3'd1, 1'b0, 16'h0008});
      stop = 1'b1; cyc(1); stop = 1'b0;
      cyc(2);
      chk("stop_idle_busy", int'(busy), 0);
      chk("stop_idle_running", int'(running), 0);
   endtask

   task automatic advance_model();
      m_ss++;
      if (m_ss == 60) begin
         m_ss = 0; m_mm++;
         if (m_mm == 60) begin
            m_mm = 0; m_hh = (m_hh == 23) ? 0 : m_hh + 1;
         end
      end
      tick_q.push_back({5'(m_hh), 6'(m_mm), 6'(m_ss),
                        alarm_en && (m_hh == alarm_hh) && (m_mm == alarm_mm) && (m_ss == 0)});
   endtask

   task automatic do_irq(input int hold);
      advance_model();
      bus_q.push_back({3'd0, 1'b0, 16'h0000});
      bus.timer_irq = 1'b1; cyc(hold); bus.timer_irq = 1'b0;
      cyc(3);
   endtask

   task automatic do_set(input int h, input int m);
      set_hh = 5'(h); set_mm = 6'(m);
      set_time = 1'b1; cyc(1); set_time = 1'b0;
      m_hh = (h > 23) ? 23 : h;
      m_mm = (m > 59) ? 59 : m;
      m_ss = 0;
   endtask

   task automatic chk_time(input string name, input int h, input int m, input int s);
      chk(name, {hh, mm, ss}, {5'(h), 6'(m), 6'(s)});
   endtask

   task automatic chk_reset_vals(input string name);
      chk(name, {bus.avm_chipselect, bus.avm_write_n, bus.avm_address, bus.avm_writedata,
                 hh, mm, ss, tick, alarm, running, cfg_error, busy},
                {1'b0, 1'b1, 3'd0, 16'h0000, 5'd0, 6'd0, 6'd0, 5'b00000});
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; set_time = 1'b0;
      set_hh = 5'd0; set_mm = 6'd0; alarm_en = 1'b0; alarm_hh = 5'd0; alarm_mm = 6'd0;
      corrupt = 1'b0; bus.timer_irq = 1'b0;
      for (int i = 0; i < 8; i++) tregs[i] = 16'h0000;
      fork
         monitor();
      join_none

      // reset state, then program and start
      cyc(2);
      chk_reset_vals("reset_values");
      reset = 1'b0; cyc(1);
      start_ok();

      // clamp of out-of-range set values
      do_set(31, 63);
      chk_time("set_clamp", 23, 59, 0);

      // rollover 23:59:00 -> 00:00:00 after 60 timeouts
      do_set(23, 59);
      chk_time("set_2359", 23, 59, 0);
      tick_cnt = 0;
      for (int i = 0; i < 60; i++) do_irq(1);
      chk_time("rollover_000000", 0, 0, 0);
      chk("tick_count_60", tick_cnt, 60);

      // alarm enabled at 07:30
      alarm_en = 1'b1; alarm_hh = 5'd7; alarm_mm = 6'd30;
      do_set(7, 29);
      alarm_cnt = 0;
      for (int i = 0; i < 60; i++) do_irq(1);
      chk("alarm_count_en", alarm_cnt, 1);
      chk_time("alarm_time", 7, 30, 0);

      // alarm disabled
      alarm_en = 1'b0;
      do_set(7, 29);
      alarm_cnt = 0;
      for (int i = 0; i < 60; i++) do_irq(1);
      chk("alarm_count_dis", alarm_cnt, 0);

      // irq held for 3 cycles -> single increment
      do_set(12, 0);
      do_irq(3);
      chk_time("irq_hold_one_inc", 12, 0, 1);

      // stop in CLR: finishes CLR_WAIT, then STOP write, then IDLE
      advance_model();
      bus_q.push_back({3'd0, 1'b0, 16'h0000});
      bus_q.push_back({3'd1, 1'b0, 16'h0008});
      bus.timer_irq = 1'b1; cyc(1);
      bus.timer_irq = 1'b0; stop = 1'b1; cyc(1);
      stop = 1'b0; chk("clr_wait_running", int'(running), 1);
      cyc(1); chk("stop_wr_busy", int'(busy), 1);
      cyc(1); chk("stop_clr_idle", {busy, running}, 0);

      // start and stop together in IDLE: nothing happens
      start = 1'b1; stop = 1'b1; cyc(1);
      start = 1'b0; stop = 1'b0; cyc(6);
      chk("start_stop_idle", {busy, running}, 0);

      // readback mismatch -> cfg_error, STOP write, IDLE
      corrupt = 1'b1;
      push_prog(1'b0);
      start = 1'b1; cyc(1); start = 1'b0;
      cyc(4);
      chk("cfg_error_set", {cfg_error, busy}, 2'b11);
      cyc(1);
      chk("cfg_error_idle", {cfg_error, busy, running}, 3'b100);
      corrupt = 1'b0;
      push_prog(1'b1);
      start = 1'b1; cyc(1); start = 1'b0;
      chk("cfg_error_clear", {cfg_error, busy}, 2'b01);
      cyc(5);
      chk("restart_running", int'(running), 1);
      do_stop();

      // reset during WR_PH
      bus_q.push_back({3'd2, 1'b0, 16'h0031});
      bus_q.push_back({3'd3, 1'b0, 16'h0000});
      start = 1'b1; cyc(1); start = 1'b0;
      cyc(1);
      reset = 1'b1; cyc(1);
      chk_reset_vals("reset_in_wr_ph");
      reset = 1'b0; m_hh = 0; m_mm = 0; m_ss = 0;
      cyc(1);
      start_ok();
      do_irq(1);
      chk_time("after_replay_tick", 0, 0, 1);

      cyc(5);
      chk("bus_queue_empty", bus_q.size(), 0);
      chk("tick_queue_empty", tick_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
